// File: rtl/button_event_ctrl_pkg.sv
// Shared event-kind codes, tracker state encoding and counter sizing helper
// for the button event controller.
package button_event_ctrl_pkg;

    localparam logic [1:0] EVT_PRESS  = 2'd0;
    localparam logic [1:0] EVT_LONG   = 2'd1;
    localparam logic [1:0] EVT_REPEAT = 2'd2;

    typedef enum logic [1:0] {
        TRK_IDLE      = 2'd0,
        TRK_PRESSED   = 2'd1,
        TRK_REPEATING = 2'd2
    } trkState_e;

    // Hold counter must be able to represent the larger of the two tick limits.
    function automatic int cntWidth(input int holdTk, input int repeatTk);
        int maxTk;
        int w;
        maxTk = (holdTk > repeatTk) ? holdTk : repeatTk;
        w = $clog2(maxTk + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_hold_tracker.sv
// Per-button press / long-press / auto-repeat tracker. Emits a one-cycle
// event strobe with its kind; release is always silent.
module btn_hold_tracker
    import button_event_ctrl_pkg::*;
#(
    parameter int HOLD_TK   = 800,
    parameter int REPEAT_TK = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level,
    input  logic       tick,
    output logic       emit,
    output logic [1:0] emit_kind
);

    localparam int CNT_W = cntWidth(HOLD_TK, REPEAT_TK);
    localparam int HOLD_I   = HOLD_TK;
    localparam int REPEAT_I = REPEAT_TK;
    localparam logic [CNT_W:0] HOLD_LIM   = HOLD_I[CNT_W:0];
    localparam logic [CNT_W:0] REPEAT_LIM = REPEAT_I[CNT_W:0];

    trkState_e        state_q, state_d;
    logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
    logic             prev_q;
    logic [CNT_W:0]   cntInc;

    // prev_q follows the level even through reset, so a button still held when
    // reset releases looks like an old press and must be re-pressed to report.
    always_ff @(posedge clk) begin
        prev_q <= level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= TRK_IDLE;
            holdCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            holdCnt_q <= holdCnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        holdCnt_d = holdCnt_q;
        emit      = 1'b0;
        emit_kind = EVT_PRESS;
        cntInc    = {1'b0, holdCnt_q} + {{CNT_W{1'b0}}, 1'b1};

        if (!level) begin
            state_d   = TRK_IDLE;
            holdCnt_d = '0;
        end else begin
            case (state_q)
                TRK_IDLE: begin
                    if (!prev_q) begin
                        emit      = 1'b1;
                        emit_kind = EVT_PRESS;
                        state_d   = TRK_PRESSED;
                        holdCnt_d = '0;
                    end
                end
                // The counter is cleared on reaching its limit, so it never wraps.
                TRK_PRESSED: begin
                    if (tick) begin
                        if (cntInc >= HOLD_LIM) begin
                            emit      = 1'b1;
                            emit_kind = EVT_LONG;
                            state_d   = TRK_REPEATING;
                            holdCnt_d = '0;
                        end else begin
                            holdCnt_d = cntInc[CNT_W-1:0];
                        end
                    end
                end
                TRK_REPEATING: begin
                    if (tick) begin
                        if (cntInc >= REPEAT_LIM) begin
                            emit      = 1'b1;
                            emit_kind = EVT_REPEAT;
                            holdCnt_d = '0;
                        end else begin
                            holdCnt_d = cntInc[CNT_W-1:0];
                        end
                    end
                end
                default: begin
                    state_d   = TRK_IDLE;
                    holdCnt_d = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_event_ctrl.sv
// Serialises per-button press/long/repeat events from NUM_BTN trackers onto a
// single valid/ready stream using one pending slot per button and fixed priority.
module button_event_ctrl
    import button_event_ctrl_pkg::*;
#(
    parameter int NUM_BTN   = 4,
    parameter int TICK_DIV  = 100000,
    parameter int HOLD_TK   = 800,
    parameter int REPEAT_TK = 200,
    parameter int ID_W      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_clean,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [ID_W-1:0]    evt_id,
    output logic [1:0]         evt_kind,
    output logic               drop_err
);

    localparam int TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TICK_LASTI = TICK_DIV - 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_LASTI[TICK_W-1:0];

    logic [TICK_W-1:0]  tickCnt_q;
    logic               tick;

    logic [NUM_BTN-1:0] emit;
    logic [1:0]         emitKind [NUM_BTN];

    logic [NUM_BTN-1:0] pendV_q, pendV_d;
    logic [1:0]         pendK_q [NUM_BTN];
    logic [1:0]         pendK_d [NUM_BTN];

    logic               evtValid_q, evtValid_d;
    logic [ID_W-1:0]    evtId_q, evtId_d;
    logic [1:0]         evtKind_q, evtKind_d;
    logic               drop_q, drop_d;

    logic               outFree;
    logic               found;
    logic [ID_W-1:0]    grantIdx;
    logic [1:0]         grantKind;
    logic [NUM_BTN-1:0] granted;
    logic               dropHit;

    assign tick = (tickCnt_q == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            tickCnt_q <= '0;
        end else begin
            tickCnt_q <= tickCnt_q + TICK_W'(1);
        end
    end

    for (genvar b = 0; b < NUM_BTN; b++) begin : gTrk
        btn_hold_tracker #(
            .HOLD_TK   (HOLD_TK),
            .REPEAT_TK (REPEAT_TK)
        ) uTrk (
            .clk       (clk),
            .rst       (rst),
            .level     (btn_clean[b]),
            .tick      (tick),
            .emit      (emit[b]),
            .emit_kind (emitKind[b])
        );
    end

    // Lowest pending index wins; a slot granted this cycle may be refilled by a
    // fresh emit in the same cycle without counting as a drop.
    always_comb begin
        outFree    = ~evtValid_q | evt_ready;
        found      = 1'b0;
        grantIdx   = '0;
        grantKind  = EVT_PRESS;
        granted    = '0;
        dropHit    = 1'b0;
        pendV_d    = pendV_q;
        pendK_d    = pendK_q;
        evtValid_d = evtValid_q;
        evtId_d    = evtId_q;
        evtKind_d  = evtKind_q;

        for (int b = 0; b < NUM_BTN; b++) begin
            if (pendV_q[b] && !found) begin
                found      = 1'b1;
                grantIdx   = ID_W'(b);
                grantKind  = pendK_q[b];
                granted[b] = outFree;
            end
        end

        for (int b = 0; b < NUM_BTN; b++) begin
            if (granted[b]) begin
                pendV_d[b] = 1'b0;
            end
            if (emit[b]) begin
                if (pendV_q[b] && !granted[b]) begin
                    dropHit = 1'b1;
                end else begin
                    pendV_d[b] = 1'b1;
                    pendK_d[b] = emitKind[b];
                end
            end
        end

        if (outFree) begin
            if (found) begin
                evtValid_d = 1'b1;
                evtId_d    = grantIdx;
                evtKind_d  = grantKind;
            end else begin
                evtValid_d = 1'b0;
            end
        end

        drop_d = drop_q | dropHit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pendV_q    <= '0;
            pendK_q    <= '{default: 2'b00};
            evtValid_q <= 1'b0;
            evtId_q    <= '0;
            evtKind_q  <= EVT_PRESS;
            drop_q     <= 1'b0;
        end else begin
            pendV_q    <= pendV_d;
            pendK_q    <= pendK_d;
            evtValid_q <= evtValid_d;
            evtId_q    <= evtId_d;
            evtKind_q  <= evtKind_d;
            drop_q     <= drop_d;
        end
    end

    assign evt_valid = evtValid_q;
    assign evt_id    = evtId_q;
    assign evt_kind  = evtKind_q;
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: cycle-exact vector table for short sequences,
// plus an event scoreboard for long holds and reset-during-hold.
module tb_button_event_ctrl;

    localparam int NUM_BTN   = 4;
    localparam int TICK_DIV  = 4;
    localparam int HOLD_TK   = 3;
    localparam int REPEAT_TK = 2;
    localparam int ID_W      = 2;

    localparam logic [1:0] K_PRESS  = 2'd0;
    localparam logic [1:0] K_LONG   = 2'd1;
    localparam logic [1:0] K_REPEAT = 2'd2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_BTN-1:0] btn_clean;
    logic               evt_valid;
    logic               evt_ready;
    logic [ID_W-1:0]    evt_id;
    logic [1:0]         evt_kind;
    logic               drop_err;

    button_event_ctrl #(
        .NUM_BTN   (NUM_BTN),
        .TICK_DIV  (TICK_DIV),
        .HOLD_TK   (HOLD_TK),
        .REPEAT_TK (REPEAT_TK),
        .ID_W      (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_clean (btn_clean),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_kind  (evt_kind),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] btn;
        logic       ready;
        logic       expV;
        logic [1:0] expId;
        logic [1:0] expK;
        logic       expDrop;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [1:0] kind;
        int         cyc;
    } evt_t;

    vec_t vecs[$];
    evt_t expQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   cyc         = 0;
    logic sbOn        = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance one clock and, while the scoreboard is live, match every visible
    // event against the oldest expected one (ready is high in those phases).
    task automatic stepCycle();
        evt_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sbOn && evt_valid) begin
            if (expQ.size() == 0) begin
                checkOutput($sformatf("unexpected event id%0d cyc%0d", evt_id, cyc), 1, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput($sformatf("sb id cyc%0d", cyc), int'(evt_id), int'(e.id));
                checkOutput($sformatf("sb kind cyc%0d", cyc), int'(evt_kind), int'(e.kind));
                checkOutput($sformatf("sb cycle id%0d", e.id), cyc, e.cyc);
            end
        end
    endtask

    task automatic doReset();
        rst       = 1'b1;
        btn_clean = '0;
        evt_ready = 1'b1;
        stepCycle();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        rst       = v.rst;
        btn_clean = v.btn;
        evt_ready = v.ready;
        stepCycle();
        if (v.rst) cyc = 0;
        checkOutput($sformatf("vec%0d valid", idx), int'(evt_valid), int'(v.expV));
        checkOutput($sformatf("vec%0d drop_err", idx), int'(drop_err), int'(v.expDrop));
        if (v.expV) begin
            checkOutput($sformatf("vec%0d id", idx), int'(evt_id), int'(v.expId));
            checkOutput($sformatf("vec%0d kind", idx), int'(evt_kind), int'(v.expK));
        end
    endtask

    function automatic void addVec(input logic r, input logic [3:0] b, input logic rd,
                                   input logic v, input logic [1:0] id, input logic [1:0] k,
                                   input logic d);
        vec_t x;
        x.rst = r; x.btn = b; x.ready = rd; x.expV = v; x.expId = id; x.expK = k; x.expDrop = d;
        vecs.push_back(x);
    endfunction

    function automatic void pushEvt(input logic [1:0] id, input logic [1:0] kind, input int c);
        evt_t e;
        e.id = id; e.kind = kind; e.cyc = c;
        expQ.push_back(e);
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int emitEdge;
        rst       = 1'b1;
        btn_clean = '0;
        evt_ready = 1'b1;

        // Short pulse on btn 1: one PRESS two cycles after the edge, nothing later.
        addVec(1, 4'b0000, 1, 0, 0, K_PRESS, 0);
        addVec(0, 4'b0010, 1, 0, 0, K_PRESS, 0);
        addVec(0, 4'b0010, 1, 1, 1, K_PRESS, 0);
        addVec(0, 4'b0000, 1, 0, 0, K_PRESS, 0);
        for (int i = 0; i < 14; i++) addVec(0, 4'b0000, 1, 0, 0, K_PRESS, 0);

        // Simultaneous edges on 0 and 2 leave in priority order on consecutive cycles.
        addVec(1, 4'b0000, 1, 0, 0, K_PRESS, 0);
        addVec(0, 4'b0101, 1, 0, 0, K_PRESS, 0);
        addVec(0, 4'b0101, 1, 1, 0, K_PRESS, 0);
        addVec(0, 4'b0101, 1, 1, 2, K_PRESS, 0);
        addVec(0, 4'b0000, 1, 0, 0, K_PRESS, 0);
        addVec(0, 4'b0000, 1, 0, 0, K_PRESS, 0);

        // Re-press of btn 1 on the cycle its pending PRESS is granted: no drop.
        addVec(1, 4'b0000, 1, 0, 0, K_PRESS, 0);
        addVec(0, 4'b0001, 0, 0, 0, K_PRESS, 0);
        addVec(0, 4'b0001, 0, 1, 0, K_PRESS, 0);
        addVec(0, 4'b0000, 0, 1, 0, K_PRESS, 0);
        addVec(0, 4'b0010, 0, 1, 0, K_PRESS, 0);
        addVec(0, 4'b0000, 0, 1, 0, K_PRESS, 0);
        addVec(0, 4'b0010, 1, 1, 1, K_PRESS, 0);
        addVec(0, 4'b0000, 1, 1, 1, K_PRESS, 0);
        addVec(0, 4'b0000, 1, 0, 0, K_PRESS, 0);

        // Back-pressure: first press held at the output, second fills the slot,
        // third is lost and drop_err sticks.
        addVec(1, 4'b0000, 1, 0, 0, K_PRESS, 0);
        addVec(0, 4'b0010, 0, 0, 0, K_PRESS, 0);
        addVec(0, 4'b0010, 0, 1, 1, K_PRESS, 0);
        addVec(0, 4'b0000, 0, 1, 1, K_PRESS, 0);
        addVec(0, 4'b0010, 0, 1, 1, K_PRESS, 0);
        addVec(0, 4'b0000, 0, 1, 1, K_PRESS, 0);
        addVec(0, 4'b0010, 0, 1, 1, K_PRESS, 1);
        addVec(0, 4'b0000, 1, 1, 1, K_PRESS, 1);
        addVec(0, 4'b0000, 1, 0, 0, K_PRESS, 1);
        addVec(0, 4'b0000, 1, 0, 0, K_PRESS, 1);

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        // Long hold on btn 3: ticks land on edges that are multiples of TICK_DIV
        // after reset, so LONG and each REPEAT emit edge follows from the limits.
        doReset();
        sbOn = 1'b1;
        btn_clean = 4'b1000;
        pushEvt(2'd3, K_PRESS, 2);
        pushEvt(2'd3, K_LONG, TICK_DIV * HOLD_TK + 1);
        for (int j = 1; j < 10; j++) begin
            emitEdge = TICK_DIV * (HOLD_TK + REPEAT_TK * j);
            if (emitEdge <= 40) pushEvt(2'd3, K_REPEAT, emitEdge + 1);
        end
        repeat (40) stepCycle();
        btn_clean = '0;
        repeat (20) stepCycle();
        checkOutput("hold scoreboard drained", expQ.size(), 0);

        // Reset in the middle of a hold: silent afterwards until a fresh press.
        doReset();
        btn_clean = 4'b0100;
        pushEvt(2'd2, K_PRESS, 2);
        repeat (3) stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        cyc = 0;
        checkOutput("reset valid", int'(evt_valid), 0);
        checkOutput("reset id", int'(evt_id), 0);
        checkOutput("reset kind", int'(evt_kind), 0);
        checkOutput("reset drop_err", int'(drop_err), 0);
        repeat (40) stepCycle();
        btn_clean = '0;
        repeat (2) stepCycle();
        btn_clean = 4'b0100;
        pushEvt(2'd2, K_PRESS, cyc + 2);
        repeat (6) stepCycle();
        btn_clean = '0;
        repeat (3) stepCycle();
        checkOutput("reset scoreboard drained", expQ.size(), 0);
        sbOn = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
